// File: rtl/fwd_pkg.sv
// Shared types for the forwarding/hazard unit: scoreboard entry, FSM state,
// and the forward-select width helper.
package fwd_pkg;

    // Scoreboard rd field is sized for the widest supported register address.
    localparam int MAX_AW = 8;

    typedef struct packed {
        logic              v;
        logic [MAX_AW-1:0] rd;
        logic              ld;
    } sbEntry_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } fsmState_t;

    function automatic int selWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match_sel.sv
// Priority encoder: the youngest scoreboard stage whose result can feed src.
module fwd_match_sel
    import fwd_pkg::*;
#(
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SEL_W      = 2
) (
    input  logic [MAX_AW-1:0]        src,
    input  sbEntry_t [FWD_DEPTH:1]   sb,
    output logic [SEL_W-1:0]         sel
);

    // Walk oldest to youngest so the smallest matching stage is the last write.
    always_comb begin
        sel = '0;
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (sb[k].v && (sb[k].rd == src) && !(sb[k].ld && (k < LOAD_STAGE)))
                sel = SEL_W'(k);
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects and load-use stall/flush for the EX stage.
// Optional FWD_HAZARD_STATS_EN adds saturating forward/stall counters.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int FWD_DEPTH  = 2,
    parameter int LOAD_STAGE = 2,
    localparam int SEL_W     = selWidth(FWD_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ex_valid_i,
    input  logic              ex_regwrite_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [REG_AW-1:0] ex_rs_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_rs_used_i,
    input  logic              id_rt_used_i,
    output logic [SEL_W-1:0]  fwd_a_o,
    output logic [SEL_W-1:0]  fwd_b_o,
    output logic              stall_o,
    output logic              flush_idex_o,
    output logic              state_o
`ifdef FWD_HAZARD_STATS_EN
    ,
    output logic [31:0]       stat_fwd_o,
    output logic [31:0]       stat_stall_o
`endif
);

    sbEntry_t [FWD_DEPTH:1] sb;
    sbEntry_t               exEntry;
    fsmState_t              state;
    logic [MAX_AW-1:0]      exRs, exRt, idRs, idRt;
    logic                   hazRs, hazRt, hazard;

    assign exRs = MAX_AW'(ex_rs_i);
    assign exRt = MAX_AW'(ex_rt_i);
    assign idRs = MAX_AW'(id_rs_i);
    assign idRt = MAX_AW'(id_rt_i);

    always_comb begin
        exEntry.v  = ex_valid_i & ex_regwrite_i & (ex_rd_i != '0);
        exEntry.rd = MAX_AW'(ex_rd_i);
        exEntry.ld = ex_memread_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sb <= '0;
        end else begin
            sb[1] <= exEntry;
            for (int k = 2; k <= FWD_DEPTH; k++)
                sb[k] <= sb[k-1];
        end
    end

    fwd_match_sel #(.FWD_DEPTH(FWD_DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) uSelA (
        .src (exRs),
        .sb  (sb),
        .sel (fwd_a_o)
    );

    fwd_match_sel #(.FWD_DEPTH(FWD_DEPTH), .LOAD_STAGE(LOAD_STAGE), .SEL_W(SEL_W)) uSelB (
        .src (exRt),
        .sb  (sb),
        .sel (fwd_b_o)
    );

    // The ID instruction reaches EX next cycle, when a load now at distance d
    // (EX=1, entry k=k+1) sits in entry d; it must be at LOAD_STAGE or beyond.
    always_comb begin
        hazRs = 1'b0;
        hazRt = 1'b0;
        if ((LOAD_STAGE > 1) && exEntry.v && exEntry.ld) begin
            hazRs = hazRs | (exEntry.rd == idRs);
            hazRt = hazRt | (exEntry.rd == idRt);
        end
        for (int k = 1; k <= FWD_DEPTH; k++) begin
            if ((k + 1 < LOAD_STAGE) && sb[k].v && sb[k].ld) begin
                hazRs = hazRs | (sb[k].rd == idRs);
                hazRt = hazRt | (sb[k].rd == idRt);
            end
        end
        hazard = rst_i & id_valid_i & ((id_rs_used_i & hazRs) | (id_rt_used_i & hazRt));
    end

    assign stall_o      = hazard;
    assign flush_idex_o = hazard;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     if (hazard)  state <= STALL;
                STALL:   if (!hazard) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign state_o = (state == STALL);

`ifdef FWD_HAZARD_STATS_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stat_fwd_o   <= '0;
            stat_stall_o <= '0;
        end else begin
            if (ex_valid_i && ((fwd_a_o != '0) || (fwd_b_o != '0)) && (stat_fwd_o != '1))
                stat_fwd_o <= stat_fwd_o + 32'd1;
            if (stall_o && (stat_stall_o != '1))
                stat_stall_o <= stat_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: a default instance (depth 2, load stage 2) and a
// depth 3 / load stage 3 instance share stimulus and a history-queue model.
module tb_fwd_hazard_unit;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    logic       exV, exRw, exMr, idV, idRsU, idRtU;
    logic [4:0] exRd, exRs, exRt, idRs, idRt;
    logic [1:0] fa2, fb2, fa3, fb3;
    logic       st2, fl2, sq2, st3, fl3, sq3;
`ifdef FWD_HAZARD_STATS_EN
    logic [31:0] sf2, ss2, sf3, ss3;
`endif

    int nTests = 0;
    int nFail  = 0;

    // History of instructions that left EX, index 1 = most recent.
    bit          hv  [1:7];
    logic [4:0]  hrd [1:7];
    bit          hld [1:7];
    bit          expSt2, expSt3;
    int unsigned cf2, cs2, cf3, cs3;

    fwd_hazard_unit uDut2 (
        .clk_i(clk), .rst_i(rst_i),
        .ex_valid_i(exV), .ex_regwrite_i(exRw), .ex_memread_i(exMr),
        .ex_rd_i(exRd), .ex_rs_i(exRs), .ex_rt_i(exRt),
        .id_valid_i(idV), .id_rs_i(idRs), .id_rt_i(idRt),
        .id_rs_used_i(idRsU), .id_rt_used_i(idRtU),
        .fwd_a_o(fa2), .fwd_b_o(fb2), .stall_o(st2), .flush_idex_o(fl2), .state_o(sq2)
`ifdef FWD_HAZARD_STATS_EN
        , .stat_fwd_o(sf2), .stat_stall_o(ss2)
`endif
    );

    fwd_hazard_unit #(.FWD_DEPTH(3), .LOAD_STAGE(3)) uDut3 (
        .clk_i(clk), .rst_i(rst_i),
        .ex_valid_i(exV), .ex_regwrite_i(exRw), .ex_memread_i(exMr),
        .ex_rd_i(exRd), .ex_rs_i(exRs), .ex_rt_i(exRt),
        .id_valid_i(idV), .id_rs_i(idRs), .id_rt_i(idRt),
        .id_rs_used_i(idRsU), .id_rt_used_i(idRtU),
        .fwd_a_o(fa3), .fwd_b_o(fb3), .stall_o(st3), .flush_idex_o(fl3), .state_o(sq3)
`ifdef FWD_HAZARD_STATS_EN
        , .stat_fwd_o(sf3), .stat_stall_o(ss3)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTests++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Youngest older instruction writing src whose data is usable at its stage.
    function automatic int expFwd(input int depth, input int ls, input logic [4:0] src);
        for (int k = 1; k <= depth; k++)
            if (hv[k] && hrd[k] == src && !(hld[k] && k < ls)) return k;
        return 0;
    endfunction

    // A load that would still be short of stage ls when the ID reader enters EX.
    function automatic bit loadBlocks(input int depth, input int ls, input logic [4:0] src);
        if (exV && exRw && exMr && exRd != 0 && exRd == src && 1 + 1 <= ls) return 1'b1;
        for (int k = 1; k <= depth; k++)
            if (hv[k] && hld[k] && hrd[k] == src && k + 1 < ls) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit expHaz(input int depth, input int ls);
        if (!rst_i || !idV) return 1'b0;
        return (idRsU && loadBlocks(depth, ls, idRs)) || (idRtU && loadBlocks(depth, ls, idRt));
    endfunction

    task automatic modelClear();
        for (int k = 1; k <= 7; k++) begin
            hv[k] = 1'b0; hrd[k] = '0; hld[k] = 1'b0;
        end
        expSt2 = 1'b0; expSt3 = 1'b0;
        cf2 = 0; cs2 = 0; cf3 = 0; cs3 = 0;
    endtask

    // Check every output of both instances, then advance one clock.
    task automatic cycle();
        int ea2, eb2, ea3, eb3;
        bit h2, h3;
        #1;
        if (!rst_i) modelClear();
        ea2 = expFwd(2, 2, exRs); eb2 = expFwd(2, 2, exRt);
        ea3 = expFwd(3, 3, exRs); eb3 = expFwd(3, 3, exRt);
        h2 = expHaz(2, 2); h3 = expHaz(3, 3);
        chk("fwdA_d2", fa2, ea2);  chk("fwdB_d2", fb2, eb2);
        chk("stall_d2", st2, h2);  chk("flush_d2", fl2, h2);  chk("state_d2", sq2, expSt2);
        chk("fwdA_d3", fa3, ea3);  chk("fwdB_d3", fb3, eb3);
        chk("stall_d3", st3, h3);  chk("flush_d3", fl3, h3);  chk("state_d3", sq3, expSt3);
`ifdef FWD_HAZARD_STATS_EN
        chk("statFwd_d2", sf2, cf2);  chk("statStall_d2", ss2, cs2);
        chk("statFwd_d3", sf3, cf3);  chk("statStall_d3", ss3, cs3);
`endif
        @(posedge clk);
        if (rst_i) begin
            expSt2 = h2; expSt3 = h3;
            if (exV && (ea2 != 0 || eb2 != 0)) cf2++;
            if (exV && (ea3 != 0 || eb3 != 0)) cf3++;
            if (h2) cs2++;
            if (h3) cs3++;
            for (int k = 7; k >= 2; k--) begin
                hv[k] = hv[k-1]; hrd[k] = hrd[k-1]; hld[k] = hld[k-1];
            end
            hv[1] = exV && exRw && exRd != 0; hrd[1] = exRd; hld[1] = exMr;
        end
        @(negedge clk);
    endtask

    task automatic setEx(input bit v, input bit rw, input bit mr,
                         input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        exV = v; exRw = rw; exMr = mr; exRd = rd; exRs = rs; exRt = rt;
    endtask

    task automatic setId(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                         input bit ru, input bit tu);
        idV = v; idRs = rs; idRt = rt; idRsU = ru; idRtU = tu;
    endtask

    task automatic drain();
        setId(0, 0, 0, 0, 0);
        repeat (3) begin
            setEx(0, 0, 0, 0, 0, 0);
            cycle();
        end
    endtask

    // lw $7 then reader $7 on the depth-3 instance: two stalls, then select 3.
    task automatic ls3Seq();
        drain();
        setEx(1, 1, 1, 7, 0, 0); setId(1, 7, 0, 1, 0);
        #1; chk("ls3_stall1", st3, 1);
        cycle();
        setEx(0, 0, 0, 0, 0, 0);
        #1; chk("ls3_stall2", st3, 1); chk("ls3_state", sq3, 1);
        cycle();
        #1; chk("ls3_stall_end", st3, 0);
        cycle();
        setEx(1, 1, 0, 11, 7, 0); setId(0, 0, 0, 0, 0);
        #1; chk("ls3_fwd", fa3, 3);
        cycle();
    endtask

    initial begin
        rst_i = 1'b0;
        setEx(0, 0, 0, 0, 0, 0);
        setId(0, 0, 0, 0, 0);
        modelClear();
        @(negedge clk);
        #1;
        chk("rst_fwdA", fa2, 0); chk("rst_stall", st2, 0); chk("rst_state", sq2, 0);
        cycle();
        rst_i = 1'b1;

        // add $3 then sub reading $3
        setEx(1, 1, 0, 3, 1, 2); cycle();
        setEx(1, 1, 0, 6, 3, 7);
        #1; chk("b2b_A", fa2, 1); chk("b2b_B", fb2, 0);
        cycle();

        // writer $5, nop, reader rt=$5
        setEx(1, 1, 0, 5, 1, 1); cycle();
        setEx(0, 0, 0, 0, 0, 0); cycle();
        setEx(1, 1, 0, 8, 1, 5);
        #1; chk("gap_B", fb2, 2);
        cycle();

        // two writers of $5, reader with rs==rt==$5
        setEx(1, 1, 0, 5, 2, 2); cycle();
        setEx(1, 1, 0, 5, 2, 2); cycle();
        setEx(1, 0, 0, 0, 5, 5);
        #1; chk("youngest_B", fb2, 1); chk("rs_eq_rt_A", fa2, 1);
        cycle();

        // load-use on the default instance: one stall, then select 2
        drain();
        setEx(1, 1, 1, 4, 0, 0); setId(1, 4, 0, 1, 0);
        #1; chk("lu_stall", st2, 1); chk("lu_flush", fl2, 1); chk("lu_state0", sq2, 0);
        cycle();
        setEx(0, 0, 0, 0, 0, 0);
        #1; chk("lu_stall_end", st2, 0); chk("lu_state1", sq2, 1);
        cycle();
        setEx(1, 1, 0, 9, 4, 0); setId(0, 0, 0, 0, 0);
        #1; chk("lu_fwd", fa2, 2); chk("lu_state2", sq2, 0);
        cycle();

        // unused rt masks a load match
        drain();
        setEx(1, 1, 1, 4, 0, 0); setId(1, 0, 4, 1, 0);
        #1; chk("mask_rt", st2, 0);
        cycle();

        // register 0 never forwards or stalls
        repeat (3) begin
            setEx(1, 1, 1, 0, 0, 0); setId(1, 0, 0, 1, 1);
            #1; chk("r0_fwdA", fa2, 0); chk("r0_stall2", st2, 0); chk("r0_stall3", st3, 0);
            cycle();
        end

        // bubble carrying rd enters the scoreboard invalid
        setId(0, 0, 0, 0, 0);
        setEx(0, 1, 0, 10, 0, 0); cycle();
        setEx(1, 0, 0, 0, 10, 0);
        #1; chk("bubble_nofwd", fa2, 0);
        cycle();

        ls3Seq();

        // reset pulsed during the second stall cycle
        drain();
        setEx(1, 1, 1, 7, 0, 0); setId(1, 7, 0, 1, 0); cycle();
        setEx(0, 0, 0, 0, 0, 0);
        #1; chk("pre_rst_stall3", st3, 1);
        rst_i = 1'b0;
        #1; chk("rst_stall3", st3, 0); chk("rst_flush3", fl3, 0); chk("rst_state3", sq3, 0);
`ifdef FWD_HAZARD_STATS_EN
        chk("rst_stat3", ss3, 0);
`endif
        cycle();
        rst_i = 1'b1;

        ls3Seq();
`ifdef FWD_HAZARD_STATS_EN
        #1; chk("stat_stall_seq", ss3, 2); chk("stat_fwd_seq", sf3, 1);
`endif

        // randomized traffic with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            rst_i = ($urandom_range(0, 63) != 0);
            setEx(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            setId(1'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom), 1'($urandom));
            cycle();
        end
        rst_i = 1'b1;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
